multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS datapath. A single unified memory and a single ALU are shared across instruction phases (fetch, decode, execute, memory, writeback). It replaces the single-cycle ControlUnit. Each state drives the mux selects, write enables and ALU opcode; memory accesses use a ready handshake with a wait timeout.

Parameters:
MAX_WAIT, 16, max cycles a memory state waits for mem_ready before error (0 = wait forever)
WAIT_W, 5, width of wait counter (must hold MAX_WAIT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completed access this cycle
pc_load  out  1  PC write enable
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
reg_write  out  1  register file write enable
reg_dst  out  2  00=rt, 01=rd, 10=$31
mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC
alu_src_a  out  1  0=PC, 1=A register
alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2
alu_op  out  4  0000 add, 0001 sub, 0010 funct-decode, 0011 and, 0100 or, 0101 slt
pc_source  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target, 11=rs
state  out  4  current state, debug/verification
instr_done  out  1  one-cycle pulse in final cycle of each instruction
err  out  2  00 none, 01 illegal opcode, 10 memory timeout

Behaviour:
- Reset (reset=0, async): state=IDLE and wait counter=0. All outputs are 0 immediately, including err. This applies mid-instruction too; no partial write completes after assertion.
- Outputs are decoded from the state register. Exceptions: pc_load, ir_write and instr_done are qualified by mem_ready/zero as listed.
- Unlisted outputs are 0 in every state.
- IDLE(0): go to FETCH on the next edge.
- FETCH(1): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00. ir_write=pc_load=mem_ready. If mem_ready, go to DECODE; otherwise stay.
- DECODE(2): alu_src_a=0, alu_src_b=11, alu_op=add (precomputes branch target). Next state:
  - lw/sw (100011/101011) -> MEM_ADDR
  - R-type with funct 001000 (jr) -> JR
  - other R-type -> EXEC
  - beq/bne (000100/000101) -> BRANCH
  - j/jal (000010/000011) -> JUMP
  - addi/slti/andi/ori (001000/001010/001100/001101) -> IMM_EXEC
  - anything else -> ERROR with err=01
- MEM_ADDR(3): alu_src_a=1, alu_src_b=10, add. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD(4): mem_read=1, i_or_d=1. If mem_ready, go to MEM_WB.
- MEM_WB(5): reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1, then FETCH.
- MEM_WR(6): mem_write=1, i_or_d=1. When mem_ready: instr_done=1 and go to FETCH.
- EXEC(7): alu_src_a=1, alu_src_b=00, alu_op=0010, then ALU_WB.
- ALU_WB(8): reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1, then FETCH.
- BRANCH(9): alu_src_a=1, alu_src_b=00, sub, pc_source=01. pc_load=zero for beq, ~zero for bne. instr_done=1, then FETCH.
- JUMP(10): pc_source=10, pc_load=1, instr_done=1. For jal also reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4). Then FETCH.
- JR(11): pc_source=11, pc_load=1, instr_done=1, then FETCH.
- IMM_EXEC(12): alu_src_a=1, alu_src_b=10. alu_op: addi=add, slti=slt, andi=and, ori=or. Then IMM_WB.
- IMM_WB(13): reg_write=1, reg_dst=00, mem_to_reg=00, instr_done=1, then FETCH.
- ERROR(14): all control outputs 0 and err holds its code. The state is sticky; only reset exits.
- Zero-wait instruction lengths: R/addi/sw 4 cycles, lw 5, beq/bne/j/jal/jr 3. Each wait cycle adds 1.
- Wait counter rules:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR and whenever mem_ready=1.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - When it reaches MAX_WAIT (MAX_WAIT>0) with mem_ready still 0, the next state is ERROR with err=10.
  - mem_ready arriving in the same cycle as the count reaching MAX_WAIT counts as success.
- mem_ready is ignored in non-memory states.
- Opcode and funct are sampled only in DECODE and MEM_ADDR (IR is stable there).

Decomposition:
- Package mips_ctrl_pkg: state encodings, opcode/funct constants, alu_op codes, and the reg_dst/mem_to_reg/alu_src_b/pc_source select codes. These are shared with alu_control and the datapath top.
- Sub-module mem_wait_timer: holds the WAIT_W counter, with inputs clear/active/ready and output timeout.

Test Plan:
- Reset release, mem_ready=1, R-type add: states 0,1,2,7,8,1. reg_write=1 with reg_dst=01 only in cycle 4 after FETCH; instr_done pulses once.
- lw with mem_ready low for 3 cycles in MEM_RD: 8 cycles total. mem_read/i_or_d=1 held throughout; MEM_WB writes rt with mem_to_reg=01.
- beq with zero=1, then beq with zero=0, then bne with zero=0: pc_load in BRANCH is 1, 0, 1 respectively, with pc_source=01.
- jal: JUMP cycle has pc_load=1, reg_write=1, reg_dst=10, mem_to_reg=10. jr: pc_source=11, reg_write=0.
- MAX_WAIT=4 with mem_ready held 0 in FETCH: ERROR after 4 wait cycles and err=10. Remains there until reset=0; then all outputs are 0 asynchronously.
- Opcode 111111 in DECODE gives ERROR with err=01. reset asserted in the middle of MEM_WR drops mem_write to 0 before the next clock edge.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, opcodes,
// ALU operation codes and datapath mux select values.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JR       = 4'd11,
    S_IMM_EXEC = 4'd12,
    S_IMM_WB   = 4'd13,
    S_ERROR    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath
// (slave): IR fields and status in, mux selects and enables out.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_load;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       instr_done;
  logic [1:0] err;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_load, i_or_d, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
           state, instr_done, err
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_load, i_or_d, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
           state, instr_done, err
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of a memory access and flags a timeout once the
// count has reached MAX_WAIT while the memory is still not ready.
module mem_wait_timer #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt;

  // Saturate at LIMIT so the counter never wraps while parked in ERROR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || ready) begin
      cnt <= '0;
    end else if (active && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A ready arriving on the limit cycle still wins over the timeout.
  assign timeout = (MAX_WAIT != 0) && active && !ready && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: one state per instruction phase, sharing a
// single memory and ALU; outputs decode from the state register.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  state_t     state_q, state_d;
  logic [1:0] err_q, err_d;
  logic [5:0] op_q;
  logic       timer_clear, timer_active, timeout;

  assign timer_active = is_mem_state(state_q);
  assign timer_clear  = is_mem_state(state_d) && (state_d != state_q);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .active  (timer_active),
    .ready   (bus.mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Later phases of branch/jump/immediate ops need the opcode after DECODE.
  always_ff @(posedge clk) begin
    if (state_q == S_DECODE) op_q <= bus.opcode;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)  state_d = S_DECODE;
        else if (timeout) begin state_d = S_ERROR; err_d = ERR_TIMEOUT; end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
          OP_RTYPE:                           state_d = (bus.funct == FN_JR) ? S_JR : S_EXEC;
          OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
          OP_J, OP_JAL:                       state_d = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  state_d = S_IMM_EXEC;
          default: begin state_d = S_ERROR; err_d = ERR_ILLEGAL; end
        endcase
      end
      S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (bus.mem_ready)  state_d = S_MEM_WB;
        else if (timeout) begin state_d = S_ERROR; err_d = ERR_TIMEOUT; end
      end
      S_MEM_WR: begin
        if (bus.mem_ready)  state_d = S_FETCH;
        else if (timeout) begin state_d = S_ERROR; err_d = ERR_TIMEOUT; end
      end
      S_EXEC:     state_d = S_ALU_WB;
      S_IMM_EXEC: state_d = S_IMM_WB;
      S_MEM_WB, S_ALU_WB, S_IMM_WB, S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.pc_load    = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = '0;
    bus.mem_to_reg = '0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = '0;
    bus.alu_op     = '0;
    bus.pc_source  = '0;
    bus.instr_done = 1'b0;
    bus.state      = state_q;
    bus.err        = err_q;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_4;
        bus.alu_op    = ALU_ADD;
        bus.pc_source = PCS_ALU;
        bus.ir_write  = bus.mem_ready;
        bus.pc_load   = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM_SH;
        bus.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = RD_RT;
        bus.mem_to_reg = M2R_MDR;
        bus.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_B;
        bus.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = RD_RD;
        bus.mem_to_reg = M2R_ALUOUT;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_op     = ALU_SUB;
        bus.pc_source  = PCS_ALUOUT;
        bus.pc_load    = (op_q == OP_BNE) ? ~bus.zero : bus.zero;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pc_source  = PCS_JUMP;
        bus.pc_load    = 1'b1;
        bus.instr_done = 1'b1;
        if (op_q == OP_JAL) begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = RD_RA;
          bus.mem_to_reg = M2R_PC;
        end
      end
      S_JR: begin
        bus.pc_source  = PCS_RS;
        bus.pc_load    = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_IMM_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        case (op_q)
          OP_SLTI: bus.alu_op = ALU_SLT;
          OP_ANDI: bus.alu_op = ALU_AND;
          OP_ORI:  bus.alu_op = ALU_OR;
          default: bus.alu_op = ALU_ADD;
        endcase
      end
      S_IMM_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and random instructions, each expanded
// into an expected per-cycle trace by an instruction-level model.
module tb_multicycle_ctrl;

  localparam int MAXW = 4;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_load, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic [1:0] err;
  } vec_t;

  typedef struct {
    vec_t v;
    logic rdy;
    logic z;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  step_t q[$];

  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MAX_WAIT(MAXW), .WAIT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic vec_t observed();
    vec_t o;
    o.st = bus.state;             o.pc_load = bus.pc_load;
    o.i_or_d = bus.i_or_d;        o.mem_read = bus.mem_read;
    o.mem_write = bus.mem_write;  o.ir_write = bus.ir_write;
    o.reg_write = bus.reg_write;  o.reg_dst = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg; o.alu_src_a = bus.alu_src_a;
    o.alu_src_b = bus.alu_src_b;  o.alu_op = bus.alu_op;
    o.pc_source = bus.pc_source;  o.instr_done = bus.instr_done;
    o.err = bus.err;
    return o;
  endfunction

  task automatic chk(input string tag, input vec_t got, input vec_t exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic vec_t ph(input logic [3:0] st);
    vec_t v = '0;
    v.st = st;
    return v;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input vec_t v, input logic rdy, input logic z);
    step_t s;
    s.v = v; s.rdy = rdy; s.z = z;
    q.push_back(s);
  endtask

  // The memory tolerates up to MAXW stalled cycles; one more is a timeout.
  task automatic add_mem(input vec_t stall, input vec_t done, input int w, output bit to);
    int low = (w > MAXW) ? MAXW + 1 : w;
    for (int i = 0; i < low; i++) push(stall, 1'b0, rbit());
    to = (w > MAXW);
    if (!to) push(done, 1'b1, rbit());
  endtask

  task automatic add_error(input logic [1:0] code);
    vec_t e = ph(4'd14);
    e.err = code;
    for (int i = 0; i < 3; i++) push(e, rbit(), rbit());
  endtask

  // Expected trace of one instruction starting in FETCH; returns 1 if it ends in ERROR.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wf, input int wm, output bit bad);
    vec_t a, b;
    bit to;
    q.delete();
    bad = 0;
    a = ph(4'd1); a.mem_read = 1; a.alu_src_b = 2'b01;
    b = a; b.ir_write = 1; b.pc_load = 1;
    add_mem(a, b, wf, to);
    if (to) begin add_error(2'b10); bad = 1; return; end
    a = ph(4'd2); a.alu_src_b = 2'b11;
    push(a, rbit(), rbit());
    if (op == 6'b100011 || op == 6'b101011) begin
      a = ph(4'd3); a.alu_src_a = 1; a.alu_src_b = 2'b10;
      push(a, rbit(), rbit());
      if (op == 6'b100011) begin
        a = ph(4'd4); a.mem_read = 1; a.i_or_d = 1;
        add_mem(a, a, wm, to);
        if (!to) begin
          a = ph(4'd5); a.reg_write = 1; a.mem_to_reg = 2'b01; a.instr_done = 1;
          push(a, rbit(), rbit());
        end
      end else begin
        a = ph(4'd6); a.mem_write = 1; a.i_or_d = 1;
        b = a; b.instr_done = 1;
        add_mem(a, b, wm, to);
      end
      if (to) begin add_error(2'b10); bad = 1; end
    end else if (op == 6'b000000 && fn == 6'b001000) begin
      a = ph(4'd11); a.pc_source = 2'b11; a.pc_load = 1; a.instr_done = 1;
      push(a, rbit(), rbit());
    end else if (op == 6'b000000) begin
      a = ph(4'd7); a.alu_src_a = 1; a.alu_op = 4'b0010;
      push(a, rbit(), rbit());
      a = ph(4'd8); a.reg_write = 1; a.reg_dst = 2'b01; a.instr_done = 1;
      push(a, rbit(), rbit());
    end else if (op == 6'b000100 || op == 6'b000101) begin
      a = ph(4'd9); a.alu_src_a = 1; a.alu_op = 4'b0001; a.pc_source = 2'b01;
      a.instr_done = 1; a.pc_load = (op == 6'b000101) ? !z : z;
      push(a, rbit(), z);
    end else if (op == 6'b000010 || op == 6'b000011) begin
      a = ph(4'd10); a.pc_source = 2'b10; a.pc_load = 1; a.instr_done = 1;
      if (op == 6'b000011) begin a.reg_write = 1; a.reg_dst = 2'b10; a.mem_to_reg = 2'b10; end
      push(a, rbit(), rbit());
    end else if (op == 6'b001000 || op == 6'b001010 || op == 6'b001100 || op == 6'b001101) begin
      a = ph(4'd12); a.alu_src_a = 1; a.alu_src_b = 2'b10;
      a.alu_op = (op == 6'b001010) ? 4'd5 : (op == 6'b001100) ? 4'd3 : (op == 6'b001101) ? 4'd4 : 4'd0;
      push(a, rbit(), rbit());
      a = ph(4'd13); a.reg_write = 1; a.instr_done = 1;
      push(a, rbit(), rbit());
    end else begin
      add_error(2'b01); bad = 1;
    end
  endtask

  // Entered at posedge+1; leaves at posedge+1 with the DUT back in FETCH.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1 chk({tag, " async-reset"}, observed(), '0);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1 chk({tag, " idle"}, observed(), ph(4'd0));
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wf, input int wm, input int abort_at);
    bit bad;
    build(op, fn, z, wf, wm, bad);
    bus.opcode = op;
    bus.funct  = fn;
    for (int i = 0; i < q.size(); i++) begin
      bus.mem_ready = q[i].rdy;
      bus.zero      = q[i].z;
      #3 chk($sformatf("%s c%0d", name, i), observed(), q[i].v);
      if (i == abort_at) begin
        do_reset({name, " abort"});
        return;
      end
      @(posedge clk); #1;
    end
    if (bad) do_reset({name, " recover"});
  endtask

  initial begin
    logic [5:0] ops [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                             6'b000011, 6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b111111};
    reset = 1'b0;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("reset state", observed(), '0);
    @(negedge clk) reset = 1'b1;
    #1 chk("idle after reset", observed(), ph(4'd0));
    @(posedge clk); #1;

    run_instr("add",     6'b000000, 6'b100000, 1'b0, 0, 0, -1);
    run_instr("lw_wait", 6'b100011, 6'b000000, 1'b0, 0, 3, -1);
    run_instr("beq_z1",  6'b000100, 6'b000000, 1'b1, 0, 0, -1);
    run_instr("beq_z0",  6'b000100, 6'b000000, 1'b0, 0, 0, -1);
    run_instr("bne_z0",  6'b000101, 6'b000000, 1'b0, 0, 0, -1);
    run_instr("jal",     6'b000011, 6'b000000, 1'b0, 1, 0, -1);
    run_instr("jr",      6'b000000, 6'b001000, 1'b0, 0, 0, -1);
    run_instr("sw_lim",  6'b101011, 6'b000000, 1'b0, 0, MAXW, -1);
    run_instr("slti",    6'b001010, 6'b000000, 1'b0, MAXW, 0, -1);
    run_instr("fetch_to", 6'b000000, 6'b100000, 1'b0, MAXW + 1, 0, -1);
    run_instr("illegal", 6'b111111, 6'b000000, 1'b0, 0, 0, -1);
    run_instr("sw_abort", 6'b101011, 6'b000000, 1'b0, 0, 3, 4);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      int wf, wm;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 2) == 0) ? 6'b001000 : 6'($urandom);
      wf = ($urandom_range(0, 15) == 0) ? MAXW + 2 : $urandom_range(0, 2);
      wm = $urandom_range(0, MAXW + 1);
      run_instr($sformatf("rnd%0d_op%b", n, op), op, fn, rbit(), wf, wm, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
